// File: rtl/picorv32_mem_arbiter_if.sv
// picorv32 native memory port (valid/ready handshake).
//   master modport: drives valid/instr/addr/wdata/wstrb, receives ready/rdata
//   slave  modport: receives the request, drives ready/rdata
// wstrb == 0 denotes a read.
interface picorv32_mem_arbiter_if;
  logic        valid;
  logic        instr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, instr, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, instr, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/picorv32_mem_arbiter.sv
// Two-master round-robin arbiter for one picorv32 native memory port.
//   clk, resetn : clock, synchronous active-low reset
//   m0, m1      : requesters (m0 = CPU, m1 = DMA/debug), slave side of the port
//   s           : shared downstream port to memory/console
//   grant       : one-hot registered owner, 00 while idle
//   timeout     : one-cycle pulse when the owner's transaction is force-completed
// One transaction per grant; the grant decision is registered, so s.valid rises
// one cycle after the winning master's valid and drops for at least one cycle
// between transactions.
module picorv32_mem_arbiter #(
  parameter int          TIMEOUT  = 1024,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                          clk,
  input  logic                          resetn,
  picorv32_mem_arbiter_if.slave         m0,
  picorv32_mem_arbiter_if.slave         m1,
  picorv32_mem_arbiter_if.master        s,
  output logic [1:0]                    grant,
  output logic                          timeout
);
  // Width holds 0..TIMEOUT; keep at least one bit when the timeout is disabled.
  localparam int          CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit          TMO_EN   = (TIMEOUT != 0);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

  state_t        r_state;
  logic [1:0]    r_grant;
  logic          r_last;   // 0 = m0 owned last, 1 = m1 owned last
  logic [CW-1:0] r_cnt;

  logic w_busy0, w_busy1, w_ov, w_done, w_tmo, w_fin;

  assign w_busy0 = (r_state == BUSY0);
  assign w_busy1 = (r_state == BUSY1);
  // Owner's valid; s.valid follows it so a dropped request is abandoned.
  assign w_ov    = (w_busy0 & m0.valid) | (w_busy1 & m1.valid);
  // s.ready beats the timeout threshold when both land in the same cycle.
  assign w_done  = w_ov & s.ready;
  assign w_tmo   = TMO_EN & w_ov & ~s.ready & (r_cnt == CNT_LAST);
  assign w_fin   = w_done | w_tmo;

  assign s.valid = w_ov;
  assign s.instr = w_busy1 ? m1.instr : m0.instr;
  assign s.addr  = w_busy1 ? m1.addr  : m0.addr;
  assign s.wdata = w_busy1 ? m1.wdata : m0.wdata;
  assign s.wstrb = w_busy1 ? m1.wstrb : m0.wstrb;

  assign m0.ready = w_busy0 & w_fin;
  assign m1.ready = w_busy1 & w_fin;
  assign m0.rdata = (w_busy0 & w_tmo) ? ERR_DATA : s.rdata;
  assign m1.rdata = (w_busy1 & w_tmo) ? ERR_DATA : s.rdata;

  assign grant   = r_grant;
  assign timeout = w_tmo;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_grant <= 2'b00;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (m0.valid && (!m1.valid || r_last)) begin
            r_state <= BUSY0;
            r_grant <= 2'b01;
          end else if (m1.valid) begin
            r_state <= BUSY1;
            r_grant <= 2'b10;
          end
        end
        BUSY0, BUSY1: begin
          if (!w_ov) begin
            // Owner withdrew without a response: drop it, fairness untouched.
            r_state <= IDLE;
            r_grant <= 2'b00;
          end else if (w_fin) begin
            r_state <= IDLE;
            r_grant <= 2'b00;
            r_last  <= w_busy1;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= 2'b00;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
module tb_picorv32_mem_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  picorv32_mem_arbiter_if m0_if ();
  picorv32_mem_arbiter_if m1_if ();
  picorv32_mem_arbiter_if s_if ();
  logic [1:0] grant;
  logic       timeout;

  picorv32_mem_arbiter #(.TIMEOUT(16), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .resetn(resetn), .m0(m0_if), .m1(m1_if), .s(s_if),
    .grant(grant), .timeout(timeout)
  );

  typedef struct { logic [31:0] rdata; logic tmo; } mexp_t;
  typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; logic instr; } sexp_t;

  mexp_t mq0[$];
  mexp_t mq1[$];
  sexp_t sq[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Slave model: RAM with strobe merge, ready after slv_lat cycles of s.valid
  // (slv_lat < 0: never responds).
  logic [31:0] ram [logic [31:0]];
  int          slv_lat = 1;
  int          scyc = 0;
  logic [31:0] wtmp;
  always @(posedge clk) begin
    #2;
    if (s_if.valid) scyc++; else scyc = 0;
    s_if.ready = 1'b0;
    s_if.rdata = 32'h0;
    if (s_if.valid && slv_lat >= 0 && scyc == slv_lat + 1) begin
      s_if.ready = 1'b1;
      wtmp = ram.exists(s_if.addr) ? ram[s_if.addr] : 32'h0;
      if (s_if.wstrb == 4'b0000) s_if.rdata = wtmp;
      else begin
        for (int b = 0; b < 4; b++)
          if (s_if.wstrb[b]) wtmp[8*b +: 8] = s_if.wdata[8*b +: 8];
        ram[s_if.addr] = wtmp;
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    mexp_t e;
    sexp_t se;
    chk("grant_onehot0", {31'b0, $onehot0(grant)}, 32'd1);
    if (m0_if.ready) begin
      chk("m0_ready_owner", {30'b0, grant}, 32'd1);
      if (mq0.size() == 0) chk("m0_unexpected_ready", {31'b0, m0_if.ready}, 32'd0);
      else begin
        e = mq0.pop_front();
        chk("m0_rdata", m0_if.rdata, e.rdata);
        chk("m0_timeout", {31'b0, timeout}, {31'b0, e.tmo});
      end
    end
    if (m1_if.ready) begin
      chk("m1_ready_owner", {30'b0, grant}, 32'd2);
      if (mq1.size() == 0) chk("m1_unexpected_ready", {31'b0, m1_if.ready}, 32'd0);
      else begin
        e = mq1.pop_front();
        chk("m1_rdata", m1_if.rdata, e.rdata);
        chk("m1_timeout", {31'b0, timeout}, {31'b0, e.tmo});
      end
    end
    if (timeout && !m0_if.ready && !m1_if.ready) chk("stray_timeout", {31'b0, timeout}, 32'd0);
    if (s_if.valid && s_if.ready) begin
      if (sq.size() == 0) chk("slave_unexpected_xfer", {31'b0, s_if.valid}, 32'd0);
      else begin
        se = sq.pop_front();
        chk("s_addr", s_if.addr, se.addr);
        chk("s_wdata", s_if.wdata, se.wdata);
        chk("s_wstrb", {28'b0, s_if.wstrb}, {28'b0, se.wstrb});
        chk("s_instr", {31'b0, s_if.instr}, {31'b0, se.instr});
      end
    end
  end

  task automatic push_s(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws, input logic ins);
    sexp_t se;
    se.addr = a; se.wdata = wd; se.wstrb = ws; se.instr = ins;
    sq.push_back(se);
  endtask

  task automatic push_m(input int m, input logic [31:0] rd, input logic tmo);
    mexp_t e;
    e.rdata = rd; e.tmo = tmo;
    if (m == 0) mq0.push_back(e); else mq1.push_back(e);
  endtask

  task automatic wait_ready(input int m, input string nm);
    bit got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = (m == 0) ? m0_if.ready : m1_if.ready;
    end
    chk(nm, {31'b0, got}, 32'd1);
  endtask

  task automatic drive(input int m, input logic v, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input logic ins);
    if (m == 0) begin
      m0_if.valid = v; m0_if.addr = a; m0_if.wdata = wd; m0_if.wstrb = ws; m0_if.instr = ins;
    end else begin
      m1_if.valid = v; m1_if.addr = a; m1_if.wdata = wd; m1_if.wstrb = ws; m1_if.instr = ins;
    end
  endtask

  // Caller is at posedge+1. Leaves valid low at posedge+1 after completion, so a
  // following call in the same process keeps valid continuously asserted.
  task automatic mreq(input int m, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                      input logic [31:0] exp, input bit do_push_s);
    push_m(m, exp, 1'b0);
    if (do_push_s) push_s(a, wd, ws, 1'b0);
    drive(m, 1'b1, a, wd, ws, 1'b0);
    wait_ready(m, "mreq_ready");
    @(posedge clk); #1;
    drive(m, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  initial begin
    int n;
    bit got;
    ram[32'h0000_0000] = 32'hC0DE_0000;
    ram[32'h0000_0004] = 32'hC0DE_0004;
    ram[32'h0000_0100] = 32'h1234_5678;
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    drive(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", {30'b0, grant}, 32'd0);
    chk("rst_s_valid", {31'b0, s_if.valid}, 32'd0);
    chk("rst_m0_ready", {31'b0, m0_if.ready}, 32'd0);
    chk("rst_m1_ready", {31'b0, m1_if.ready}, 32'd0);
    chk("rst_timeout", {31'b0, timeout}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Single read with 1-cycle arbitration latency
    repeat (2) @(posedge clk); #1;
    slv_lat = 1;
    push_m(0, 32'h1234_5678, 1'b0);
    push_s(32'h100, 32'h0, 4'h0, 1'b1);
    drive(0, 1'b1, 32'h100, 32'h0, 4'h0, 1'b1);
    @(negedge clk);
    chk("sr_s_valid_arb", {31'b0, s_if.valid}, 32'd0);
    chk("sr_grant_arb", {30'b0, grant}, 32'd0);
    @(negedge clk);
    chk("sr_s_valid_rise", {31'b0, s_if.valid}, 32'd1);
    chk("sr_grant_busy", {30'b0, grant}, 32'd1);
    @(negedge clk);
    chk("sr_m0_ready", {31'b0, m0_if.ready}, 32'd1);
    @(posedge clk); #1;
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    chk("sr_grant_done", {30'b0, grant}, 32'd0);

    // s_ready while IDLE is ignored
    slv_lat = 0;
    @(posedge clk); #1;
    repeat (2) @(negedge clk);
    chk("idle_grant", {30'b0, grant}, 32'd0);

    // Contention after reset: alternation m0,m1,...
    @(posedge clk); #1;
    resetn = 1'b0;
    repeat (2) @(posedge clk); #1;
    resetn = 1'b1;
    slv_lat = 1;
    for (int i = 0; i < 4; i++) begin
      push_s(32'h0, 32'h0, 4'h0, 1'b0);
      push_s(32'h4, 32'h0, 4'h0, 1'b0);
    end
    fork
      for (int i = 0; i < 4; i++) mreq(0, 32'h0, 32'h0, 4'h0, 32'hC0DE_0000, 1'b0);
      for (int j = 0; j < 4; j++) mreq(1, 32'h4, 32'h0, 4'h0, 32'hC0DE_0004, 1'b0);
    join

    // Write forwarding then readback
    @(posedge clk); #1;
    mreq(1, 32'h200, 32'hA5A5_A5A5, 4'b0011, 32'h0, 1'b1);
    mreq(0, 32'h200, 32'h0, 4'h0, 32'h0000_A5A5, 1'b1);

    // Timeout: dead slave
    @(posedge clk); #1;
    slv_lat = -1;
    push_m(0, 32'hDEAD_BEEF, 1'b1);
    drive(0, 1'b1, 32'h300, 32'h0, 4'h0, 1'b0);
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (s_if.valid) n++;
      got = m0_if.ready;
    end
    chk("tmo_s_valid_cycles", n, 32'd16);
    chk("tmo_pulse", {31'b0, timeout}, 32'd1);
    @(posedge clk); #1;
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    chk("tmo_grant_after", {30'b0, grant}, 32'd0);
    chk("tmo_s_valid_after", {31'b0, s_if.valid}, 32'd0);

    // Timeout race: s_ready in the 16th BUSY cycle wins
    slv_lat = 15;
    @(posedge clk); #1;
    mreq(0, 32'h100, 32'h0, 4'h0, 32'h1234_5678, 1'b1);

    // Reset mid-transaction while BUSY1
    slv_lat = -1;
    @(posedge clk); #1;
    drive(1, 1'b1, 32'h400, 32'h0, 4'h0, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = (grant == 2'b10);
    end
    chk("mrst_busy1", {30'b0, grant}, 32'd2);
    @(posedge clk); #1;
    resetn = 1'b0;
    drive(0, 1'b1, 32'h100, 32'h0, 4'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("mrst_s_valid", {31'b0, s_if.valid}, 32'd0);
    chk("mrst_grant", {30'b0, grant}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    slv_lat = 1;
    push_m(0, 32'h1234_5678, 1'b0);
    push_m(1, 32'h0, 1'b0);
    push_s(32'h100, 32'h0, 4'h0, 1'b0);
    push_s(32'h400, 32'h0, 4'h0, 1'b0);
    repeat (2) @(negedge clk);
    chk("mrst_tie_m0", {30'b0, grant}, 32'd1);
    wait_ready(0, "mrst_m0_ready");
    @(posedge clk); #1;
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    wait_ready(1, "mrst_m1_ready");
    @(posedge clk); #1;
    drive(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

    repeat (3) @(negedge clk);
    chk("mq0_drained", mq0.size(), 32'd0);
    chk("mq1_drained", mq1.size(), 32'd0);
    chk("sq_drained", sq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
